mem_access_unit: RTL and testbench

- Memory-stage consumer of the execute/memory pipeline register.
- Turns a latched load/store into a data-bus request and holds the pipeline stalled until the bus responds.
- Aligns store data and byte strobes; extracts, sign-extends or zero-extends load data.
- Produces a one-cycle completion pulse consumed by the memory/writeback pipeline register.

---
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
    parameter int XLEN = 64
);
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [2:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic            dresp_addr_ok;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one data-bus request per memory op and stalls until it completes.
// Optional build macro MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module mem_access_unit #(
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_is_load,
    input  logic                 in_is_store,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_addr,
    input  logic [XLEN-1:0]      in_wdata,
    output logic                 stall,
    mem_access_unit_if.master    dbus,
    output logic                 out_done,
    output logic [XLEN-1:0]      out_rdata,
    output logic                 exc_misaligned
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic            mem_op;
    logic            misaligned;
    logic [2:0]      off_in;
    logic [7:0]      size_mask;
    logic [14:0]     strobe_wide;
    logic [7:0]      strobe_in;
    logic [XLEN-1:0] wdata_in;

    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic [7:0]      strobe_q;
    logic [XLEN-1:0] data_q;
    logic [2:0]      funct3_q;
    logic            is_store_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] load_shifted;
    logic [XLEN-1:0] load_fmt;

    assign mem_op = in_valid & (in_is_load | in_is_store);
    assign off_in = in_addr[2:0];

    always_comb begin
        case (in_funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off; loads carry no strobes and no write data.
    assign strobe_wide = {7'd0, size_mask} << off_in;
    assign strobe_in   = in_is_store ? strobe_wide[7:0] : 8'h00;
    assign wdata_in    = in_is_store ? (in_wdata << {off_in, 3'b000}) : '0;

`ifdef MEM_MISALIGN_CHECK_EN
    logic [3:0] size_bytes;
    logic [3:0] align_bits;
    logic       exc_q;

    assign size_bytes     = 4'd1 << in_funct3[1:0];
    assign align_bits     = size_bytes - 4'd1;
    assign misaligned     = |(off_in & align_bits[2:0]);
    assign exc_misaligned = exc_q & (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else if (state == IDLE && mem_op) begin
            exc_q <= misaligned;
        end
    end
`else
    assign misaligned     = 1'b0;
    assign exc_misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    state_next = misaligned ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dbus.dresp_data_ok) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the addressed bytes of the returned word, then sign- or zero-extend by access size.
    always_comb begin
        load_shifted = dbus.dresp_data >> {addr_q[2:0], 3'b000};
        load_fmt     = load_shifted;
        case (size_q)
            2'd0: load_fmt = funct3_q[2] ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                                         : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_fmt = funct3_q[2] ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                                         : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_fmt = funct3_q[2] ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                                         : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
            default: load_fmt = load_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= 2'd0;
            strobe_q   <= 8'h00;
            data_q     <= '0;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        addr_q     <= in_addr;
                        size_q     <= in_funct3[1:0];
                        strobe_q   <= strobe_in;
                        data_q     <= wdata_in;
                        funct3_q   <= in_funct3;
                        is_store_q <= in_is_store;
                        rdata_q    <= '0;
                    end
                end
                WAIT: begin
                    if (dbus.dresp_data_ok) begin
                        rdata_q <= is_store_q ? '0 : load_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus.dreq_valid  = (state == WAIT);
    assign dbus.dreq_addr   = addr_q;
    assign dbus.dreq_size   = {1'b0, size_q};
    assign dbus.dreq_strobe = strobe_q;
    assign dbus.dreq_data   = data_q;
    assign out_done         = (state == DONE);
    assign out_rdata        = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected requests/completions, a monitor pops and compares.
module tb_mem_access_unit;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_is_load, in_is_store;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr, in_wdata;
    logic            stall, out_done, exc_misaligned;
    logic [XLEN-1:0] out_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        exc;
        int          cycle;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    req_t  cur_req;
    logic  prev_valid;

    mem_access_unit_if #(.XLEN(XLEN)) dbus ();

    mem_access_unit #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .stall          (stall),
        .dbus           (dbus),
        .out_done       (out_done),
        .out_rdata      (out_rdata),
        .exc_misaligned (exc_misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane view of the access, built from the RISC-V load/store rules.
    function automatic void model(input logic is_store, input logic [2:0] f3, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] raw,
                                  output req_t r, output logic [63:0] rd, output logic mis);
        int nb  = 1 << f3[1:0];
        int off = int'(addr[2:0]);
        r.addr   = addr;
        r.size   = {1'b0, f3[1:0]};
        r.strobe = 8'h00;
        r.data   = 64'd0;
        rd       = 64'd0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (off % nb) != 0;
`else
        mis = 1'b0;
`endif
        if (is_store) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= off && i < off + nb) r.strobe[i] = 1'b1;
                if (i >= off) r.data[8*i +: 8] = wdata[8*(i-off) +: 8];
            end
        end else begin
            for (int k = 0; k < nb; k++)
                if (off + k < 8) rd[8*k +: 8] = raw[8*(off+k) +: 8];
            if (!f3[2] && nb < 8 && rd[8*nb-1])
                for (int b = 8*nb; b < 64; b++) rd[b] = 1'b1;
        end
        if (mis) rd = 64'd0;
    endfunction

    // Present one instruction, act as the memory with the given response latency, hold it through DONE.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] raw, input int lat);
        req_t        r;
        logic [63:0] rd;
        logic        mis;
        int          a;
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wdata;
        #1;
        checkOutput("stall_accept", 64'(stall), 64'(ld | st));
        if (!(ld | st)) begin
            @(posedge clk); #1;
            checkOutput("no_req_nonmem", 64'(dbus.dreq_valid), 64'd0);
            in_valid = 1'b0;
            return;
        end
        model(st, f3, addr, wdata, raw, r, rd, mis);
        @(posedge clk); #1;
        a = cyc;
        if (!mis) req_q.push_back(r);
        done_q.push_back('{rdata: rd, exc: mis, cycle: (mis ? a : a + lat + 1)});
        if (!mis) begin
            for (int i = 0; i < lat; i++) begin
                dbus.dresp_addr_ok = 1'($urandom);
                @(posedge clk); #1;
            end
            dbus.dresp_data_ok = 1'b1;
            dbus.dresp_addr_ok = 1'($urandom);
            dbus.dresp_data    = raw;
            @(posedge clk); #1;
            dbus.dresp_data_ok = 1'b0;
            dbus.dresp_addr_ok = 1'b0;
            dbus.dresp_data    = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (dbus.dreq_valid) begin
                checkOutput("stall_wait", 64'(stall), 64'd1);
                if (!prev_valid) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_req: got dreq_valid=1, expected no request");
                    end else begin
                        cur_req = req_q.pop_front();
                    end
                end
                checkOutput("dreq_addr",   dbus.dreq_addr,         cur_req.addr);
                checkOutput("dreq_size",   64'(dbus.dreq_size),    64'(cur_req.size));
                checkOutput("dreq_strobe", 64'(dbus.dreq_strobe),  64'(cur_req.strobe));
                checkOutput("dreq_data",   dbus.dreq_data,         cur_req.data);
            end
            if (out_done) begin
                checkOutput("stall_done", 64'(stall), 64'd0);
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got out_done=1, expected no completion");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    checkOutput("out_rdata",      out_rdata,               d.rdata);
                    checkOutput("exc_misaligned", 64'(exc_misaligned),     64'(d.exc));
                    checkOutput("done_cycle",     64'(cyc),                64'(d.cycle));
                end
            end
            prev_valid <= dbus.dreq_valid;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dreq_valid"}, 64'(dbus.dreq_valid),  64'd0);
        checkOutput({tag, "_stall"},      64'(stall),            64'd0);
        checkOutput({tag, "_out_done"},   64'(out_done),         64'd0);
        checkOutput({tag, "_out_rdata"},  out_rdata,             64'd0);
        checkOutput({tag, "_dreq_addr"},  dbus.dreq_addr,        64'd0);
        checkOutput({tag, "_dreq_strb"},  64'(dbus.dreq_strobe), 64'd0);
        checkOutput({tag, "_dreq_data"},  dbus.dreq_data,        64'd0);
        checkOutput({tag, "_dreq_size"},  64'(dbus.dreq_size),   64'd0);
        checkOutput({tag, "_exc"},        64'(exc_misaligned),   64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] addr;
        logic        ld, st;
        int          kind;
        reset = 1'b1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
        dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0; dbus.dresp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("reset");

        $display("[TB] directed cases");
        applyStimulus(1'b0, 1'b1, 3'd0, 64'h1003, 64'hAB, 64'h0, 2);
        applyStimulus(1'b1, 1'b0, 3'd0, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 1);
        applyStimulus(1'b1, 1'b0, 3'd4, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 3);
        applyStimulus(1'b1, 1'b0, 3'd2, 64'h10, 64'h0, 64'h1234_5678_8765_4321, 0);
        applyStimulus(1'b1, 1'b0, 3'd6, 64'h10, 64'h0, 64'h1234_5678_8765_4321, 0);
        applyStimulus(1'b0, 1'b0, 3'd3, 64'h40, 64'h0, 64'h0, 0);
        applyStimulus(1'b0, 1'b1, 3'd3, 64'h18, 64'hDEAD_BEEF_0123_4567, 64'h0, 1);
        applyStimulus(1'b1, 1'b1, 3'd1, 64'h22, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        applyStimulus(1'b1, 1'b0, 3'd1, 64'h3001, 64'h0, 64'h0000_0000_00C0_FE00, 1);

        $display("[TB] reset during WAIT");
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
        in_funct3 = 3'd3; in_addr = 64'h40; in_wdata = '0;
        req_q.push_back('{addr: 64'h40, size: 3'd3, strobe: 8'h00, data: 64'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dbus.dresp_data_ok = 1'b1;
        dbus.dresp_data    = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        dbus.dresp_data_ok = 1'b0;
        checkAllZero("rst_wait");
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("rst_after");

        $display("[TB] random cases");
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                ld = 1'b0; st = 1'b0;
            end else begin
                ld = 1'($urandom); st = 1'($urandom);
                if (!ld && !st) ld = 1'b1;
            end
            f3   = st ? {1'b0, 2'($urandom)} : 3'($urandom);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            applyStimulus(ld, st, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                          int'($urandom_range(0, 4)));
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("pending_req",  64'(req_q.size()),  64'd0);
        checkOutput("pending_done", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
